dadda_mult_pipe: RTL and testbench

- Parametrised, pipelined Dadda-tree multiplier. Generalises the team's fixed 4-bit combinational multiplier to WIDTH x WIDTH operands.
- Adds a per-transaction signed/unsigned mode (Baugh-Wooley partial products) and a valid/ready handshake with backpressure.
- Carries a user tag through the pipeline alongside each product.
- Sits between the datapath operand sequencer and the accumulator.

---
 rtl/dadda_pkg.sv | 36 +++
 rtl/dadda_tree.sv | 108 ++++++++++
 rtl/dadda_mult_pipe.sv | 91 +++++++++
 tb/tb_dadda_mult_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dadda_pkg.sv
// Shared constants and helpers for the Dadda multiplier: height sequence,
// level count and the FA/HA cells used by the reduction tree.
package dadda_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  // Dadda target heights: 2,3,4,6,9,13,19,28,42,...
  function automatic int unsigned dadda_height(input int unsigned level);
    int unsigned d;
    d = 2;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < level) d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Number of reduction levels needed for a WIDTH x WIDTH matrix (max height WIDTH).
  function automatic int unsigned dadda_levels(input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (dadda_height(i) < width) n = i + 1;
    end
    return n;
  endfunction

  // Returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/dadda_tree.sv
// Combinational Baugh-Wooley partial products and Dadda reduction to two rows.
module dadda_tree
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] row0,
  output logic [2*WIDTH-1:0] row1
);

  localparam int unsigned COLS   = 2 * WIDTH + 1;  // top column only sinks dropped carries
  localparam int unsigned DEPTH  = WIDTH + 2;
  localparam int unsigned LEVELS = dadda_levels(WIDTH);

  always_comb begin
    logic [DEPTH-1:0] cur [COLS];
    logic [DEPTH-1:0] nxt [COLS];
    int unsigned      ht  [COLS];
    int unsigned      nht [COLS];
    int unsigned      d, cnt, ptr;
    logic [1:0]       r;
    logic             pp;

    for (int unsigned c = 0; c < COLS; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      ht[c]  = 0;
      nht[c] = 0;
    end
    d   = 0;
    cnt = 0;
    ptr = 0;
    r   = '0;
    pp  = 1'b0;
    row0 = '0;
    row1 = '0;

    // Signed mode inverts the MSB row/column (except the corner) and adds 1s at bits W and 2W-1.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp = a[i] & b[j];
        if (is_signed && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
        cur[i+j][ht[i+j]] = pp;
        ht[i+j]++;
      end
    end
    cur[WIDTH][ht[WIDTH]] = is_signed;
    ht[WIDTH]++;
    cur[2*WIDTH-1][ht[2*WIDTH-1]] = is_signed;
    ht[2*WIDTH-1]++;

    // Each level: carries from column c-1 land in nxt[c] first; compress old bits
    // only until the column (old + carries in + new sums) fits the target height.
    for (int unsigned l = 0; l < LEVELS; l++) begin
      d = dadda_height(LEVELS - 1 - l);
      for (int unsigned c = 0; c < COLS; c++) begin
        nxt[c] = '0;
        nht[c] = 0;
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        cnt = ht[c] + nht[c];
        ptr = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (cnt > d && cnt - d >= 2 && ptr + 3 <= ht[c]) begin
            r = full_add(cur[c][ptr], cur[c][ptr+1], cur[c][ptr+2]);
            ptr = ptr + 3;
            cnt = cnt - 2;
            nxt[c][nht[c]] = r[0];
            nht[c]++;
            if (c + 1 < COLS) begin
              nxt[c+1][nht[c+1]] = r[1];
              nht[c+1]++;
            end
          end else if (cnt > d && ptr + 2 <= ht[c]) begin
            r = half_add(cur[c][ptr], cur[c][ptr+1]);
            ptr = ptr + 2;
            cnt = cnt - 1;
            nxt[c][nht[c]] = r[0];
            nht[c]++;
            if (c + 1 < COLS) begin
              nxt[c+1][nht[c+1]] = r[1];
              nht[c+1]++;
            end
          end
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (k >= ptr && k < ht[c]) begin
            nxt[c][nht[c]] = cur[c][k];
            nht[c]++;
          end
        end
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        cur[c] = nxt[c];
        ht[c]  = nht[c];
      end
    end

    for (int unsigned c = 0; c < 2 * WIDTH; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
  end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Dadda multiplier with signed/unsigned mode,
// sideband tag and valid/ready handshake under a single global stall.
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  logic               stall;
  logic               accept;

  logic               s0_valid;
  logic               s0_signed;
  logic [WIDTH-1:0]   s0_a;
  logic [WIDTH-1:0]   s0_b;
  logic [TAG_W-1:0]   s0_tag;

  logic               s1_valid;
  logic [2*WIDTH-1:0] s1_row0;
  logic [2*WIDTH-1:0] s1_row1;
  logic [TAG_W-1:0]   s1_tag;

  logic               s2_valid;
  logic [2*WIDTH-1:0] s2_p;
  logic [TAG_W-1:0]   s2_tag;

  logic [2*WIDTH-1:0] tree_row0;
  logic [2*WIDTH-1:0] tree_row1;

  assign stall     = s2_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;
  assign out_p     = s2_p;
  assign out_tag   = s2_tag;

  dadda_tree #(.WIDTH(WIDTH)) u_tree (
    .a         (s0_a),
    .b         (s0_b),
    .is_signed (s0_signed),
    .row0      (tree_row0),
    .row1      (tree_row1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid  <= 1'b0;
      s0_signed <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_tag    <= '0;
      s1_valid  <= 1'b0;
      s1_row0   <= '0;
      s1_row1   <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_p      <= '0;
      s2_tag    <= '0;
    end else if (!stall) begin
      s0_valid <= accept;
      if (accept) begin
        s0_signed <= in_signed;
        s0_a      <= in_a;
        s0_b      <= in_b;
        s0_tag    <= in_tag;
      end
      s1_valid <= s0_valid;
      s1_row0  <= tree_row0;
      s1_row1  <= tree_row1;
      s1_tag   <= s0_tag;
      s2_valid <= s1_valid;
      s2_p     <= s1_row0 + s1_row1;
      s2_tag   <= s1_tag;
    end
  end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Self-checking bench: directed vector table, backpressure and reset sequences at
// WIDTH=8, then a randomized scoreboard run at WIDTH=4, 8, 13 and 32.
module tb_dadda_mult_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned NV = 12;
  localparam int unsigned ISSUE_CYC = 19000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_ready, in_signed;
  logic [W-1:0]    in_a, in_b;
  logic [TW-1:0]   in_tag;
  logic            out_valid, out_ready;
  logic [2*W-1:0]  out_p;
  logic [TW-1:0]   out_tag;

  int checks = 0;
  int errors = 0;

  dadda_mult_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  // Randomized instances share stimulus; each keeps its own scoreboard.
  logic          r_rst_n;
  logic          r_in_valid, r_in_signed, r_out_ready;
  logic [31:0]   r_in_a, r_in_b;
  logic [TW-1:0] r_in_tag;
  logic          r_in_ready  [4];
  logic          r_out_valid [4];
  logic [63:0]   r_out_p     [4];
  logic [TW-1:0] r_out_tag   [4];
  int unsigned   rw [4] = '{4, 8, 13, 32};

  for (genvar g = 0; g < 4; g++) begin : g_rand
    localparam int unsigned RW = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 13 : 32;
    logic [2*RW-1:0] p;
    dadda_mult_pipe #(.WIDTH(RW), .TAG_W(TW)) u_dut (
      .clk       (clk),
      .rst_n     (r_rst_n),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready[g]),
      .in_signed (r_in_signed),
      .in_a      (r_in_a[RW-1:0]),
      .in_b      (r_in_b[RW-1:0]),
      .in_tag    (r_in_tag),
      .out_valid (r_out_valid[g]),
      .out_ready (r_out_ready),
      .out_p     (p),
      .out_tag   (r_out_tag[g])
    );
    assign r_out_p[g] = 64'(p);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Exact product of w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm;
    longint      sa, sb;
    logic [63:0] p;
    am = a & (32'hFFFF_FFFF >> (32 - w));
    bm = b & (32'hFFFF_FFFF >> (32 - w));
    if (sgn) begin
      sa = longint'({32'b0, am});
      sb = longint'({32'b0, bm});
      if (am[w-1]) sa = sa - longint'(64'd1 << w);
      if (bm[w-1]) sb = sb - longint'(64'd1 << w);
      p = 64'(sa * sb);
    end else begin
      p = {32'b0, am} * {32'b0, bm};
    end
    return p & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  typedef struct {
    logic          sgn;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [TW-1:0] tag;
    logic [15:0]   p;
  } vec_t;

  vec_t          vt [NV];
  logic [63:0]   eq [4][$];
  logic [TW-1:0] tq [4][$];

  initial begin
    logic [63:0]   bq [$];
    logic [TW-1:0] btq [$];
    logic [7:0]    ops_a [6];
    logic [7:0]    ops_b [6];
    logic          ops_s [6];
    logic          held, h_held [4];
    logic [15:0]   held_p;
    logic [63:0]   h_p [4];
    logic [TW-1:0] held_t, h_t [4];
    int            sent, recv, stalls;
    logic [63:0]   e;

    vt[0]  = '{1'b0, 8'hFF, 8'hFF, 4'h5, 16'hFE01};
    vt[1]  = '{1'b1, 8'h80, 8'h80, 4'h1, 16'h4000};
    vt[2]  = '{1'b1, 8'hFF, 8'h01, 4'h2, 16'hFFFF};
    vt[3]  = '{1'b1, 8'h7F, 8'h80, 4'h3, 16'hC080};
    vt[4]  = '{1'b0, 8'h80, 8'h80, 4'h4, 16'h4000};
    vt[5]  = '{1'b0, 8'h00, 8'hAB, 4'h6, 16'h0000};
    vt[6]  = '{1'b1, 8'h7F, 8'h7F, 4'h7, 16'h3F01};
    vt[7]  = '{1'b1, 8'hFF, 8'hFF, 4'h8, 16'h0001};
    vt[8]  = '{1'b0, 8'h0F, 8'h11, 4'h9, 16'h00FF};
    vt[9]  = '{1'b1, 8'h80, 8'h01, 4'hA, 16'hFF80};
    vt[10] = '{1'b1, 8'h05, 8'hFD, 4'hB, 16'hFFF1};
    vt[11] = '{1'b0, 8'hFF, 8'h01, 4'hC, 16'h00FF};

    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b1;
    r_rst_n = 1'b0; r_in_valid = 1'b0; r_in_signed = 1'b0; r_in_a = '0; r_in_b = '0;
    r_in_tag = '0; r_out_ready = 1'b1;

    @(negedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_p", 64'(out_p), 0);
    chk("rst_out_tag", 64'(out_tag), 0);
    @(negedge clk);
    rst_n = 1'b1; r_rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 1);

    // Back-to-back table: entry c must appear exactly three edges after it is driven.
    for (int c = 0; c < int'(NV) + 4; c++) begin
      @(negedge clk);
      if (c < int'(NV)) begin
        in_valid = 1'b1; in_signed = vt[c].sgn; in_a = vt[c].a; in_b = vt[c].b; in_tag = vt[c].tag;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < int'(NV)) chk("vec_in_ready", 64'(in_ready), 1);
      if (c >= 3 && c < int'(NV) + 3) begin
        chk("vec_out_valid", 64'(out_valid), 1);
        chk("vec_out_p", 64'(out_p), 64'(vt[c-3].p));
        chk("vec_out_tag", 64'(out_tag), 64'(vt[c-3].tag));
      end else begin
        chk("vec_out_idle", 64'(out_valid), 0);
      end
    end

    // Backpressure: out_ready low for cycles 4..8 while streaming 6 ops.
    for (int i = 0; i < 6; i++) begin
      ops_a[i] = 8'($urandom); ops_b[i] = 8'($urandom); ops_s[i] = 1'(i % 2);
    end
    sent = 0; recv = 0; stalls = 0; held = 1'b0; held_p = '0; held_t = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 8);
      if (sent < 6) begin
        in_valid = 1'b1; in_a = ops_a[sent]; in_b = ops_b[sent]; in_signed = ops_s[sent];
        in_tag = TW'(sent + 3);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        chk("bp_hold_valid", 64'(out_valid), 1);
        chk("bp_hold_p", 64'(out_p), 64'(held_p));
        chk("bp_hold_tag", 64'(out_tag), 64'(held_t));
      end
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", 64'(in_ready), 0);
        stalls++;
      end
      if (in_valid && in_ready) begin
        bq.push_back(ref_mul(W, in_signed, 32'(in_a), 32'(in_b)));
        btq.push_back(in_tag);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (bq.size() == 0) begin
          chk("bp_spurious", 64'(out_valid), 0);
        end else begin
          chk("bp_out_p", 64'(out_p), bq.pop_front());
          chk("bp_out_tag", 64'(out_tag), 64'(btq.pop_front()));
          recv++;
        end
      end
      held = out_valid && !out_ready; held_p = out_p; held_t = out_tag;
    end
    chk("bp_count", 64'(recv), 6);
    chk("bp_stall_seen", 64'(stalls == 5), 1);

    // Reset with three operations in flight.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0; in_a = 8'(c + 7); in_b = 8'h3; in_tag = TW'(c + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rmf_pre_valid", 64'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmf_out_valid", 64'(out_valid), 0);
    chk("rmf_out_p", 64'(out_p), 0);
    chk("rmf_out_tag", 64'(out_tag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk("rmf_no_stale", 64'(out_valid), 0);
      chk("rmf_in_ready", 64'(in_ready), 1);
    end

    // Randomized regression across widths, scoreboard against plain arithmetic.
    for (int g = 0; g < 4; g++) begin
      h_held[g] = 1'b0; h_p[g] = '0; h_t[g] = '0;
    end
    for (int cyc = 0; cyc < int'(ISSUE_CYC) + 30; cyc++) begin
      @(negedge clk);
      r_in_valid  = (cyc < int'(ISSUE_CYC)) && ($urandom_range(0, 9) < 7);
      r_in_signed = 1'($urandom_range(0, 1));
      r_in_a      = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
      r_in_b      = ($urandom_range(0, 7) == 0) ? 32'h8000_8888 : $urandom;
      r_in_tag    = TW'($urandom);
      r_out_ready = (cyc >= int'(ISSUE_CYC)) || ($urandom_range(0, 3) != 0);
      #1;
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("rand_in_ready_w%0d", rw[g]), 64'(r_in_ready[g]),
            64'(!(r_out_valid[g] && !r_out_ready)));
        if (h_held[g]) begin
          chk($sformatf("rand_hold_p_w%0d", rw[g]), r_out_p[g], h_p[g]);
          chk($sformatf("rand_hold_tag_w%0d", rw[g]), 64'(r_out_tag[g]), 64'(h_t[g]));
        end
        if (r_in_valid && r_in_ready[g]) begin
          eq[g].push_back(ref_mul(rw[g], r_in_signed, r_in_a, r_in_b));
          tq[g].push_back(r_in_tag);
        end
        if (r_out_valid[g] && r_out_ready) begin
          if (eq[g].size() == 0) begin
            chk($sformatf("rand_spurious_w%0d", rw[g]), 64'(r_out_valid[g]), 0);
          end else begin
            e = eq[g].pop_front();
            chk($sformatf("rand_p_w%0d", rw[g]), r_out_p[g], e);
            chk($sformatf("rand_tag_w%0d", rw[g]), 64'(r_out_tag[g]), 64'(tq[g].pop_front()));
          end
        end
        h_held[g] = r_out_valid[g] && !r_out_ready;
        h_p[g] = r_out_p[g];
        h_t[g] = r_out_tag[g];
      end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rand_drain_w%0d", rw[g]), 64'(eq[g].size()), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
